digilock_param: RTL



---
 rtl/digilock_pkg.sv | 30 +++
 rtl/digilock_blink.sv | 31 +++
 rtl/digilock_param.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/digilock_pkg.sv
// Shared definitions for the parametrised digit lock: state encoding and glyph codes.
// Optional confirm-on-change behaviour is selected with macro DIGILOCK_CONFIRM_EN.
package digilock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    NEWPW   = 3'd4,
    LOCKOUT = 3'd5
`ifdef DIGILOCK_CONFIRM_EN
    ,
    CONFIRM = 3'd7
`endif
  } state_t;

  // 5-bit glyph codes understood by the binary-to-segment stage
  localparam logic [4:0] G_0     = 5'd0;
  localparam logic [4:0] G_5     = 5'd5;
  localparam logic [4:0] G_C     = 5'd12;
  localparam logic [4:0] G_E     = 5'd14;
  localparam logic [4:0] G_BLANK = 5'd16;
  localparam logic [4:0] G_L     = 5'd17;
  localparam logic [4:0] G_D     = 5'd18;
  localparam logic [4:0] G_P     = 5'd19;
  localparam logic [4:0] G_N     = 5'd20;
  localparam logic [4:0] G_DASH  = 5'd21;

endpackage

// File: rtl/digilock_blink.sv
// Blink phase generator for the digit being entered; restart forces phase on.
module digilock_blink #(
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase
);

  localparam int unsigned CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Count 0..BLINK_CYCLES-1 and toggle the phase on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(BLINK_CYCLES - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/digilock_param.sv
// Parametrised N-digit lock controller: code entry, attempt counting, timed lockout,
// password change, glyph bus and status LEDs. Define DIGILOCK_CONFIRM_EN to require
// the new password to be entered twice before it is committed.
module digilock_param #(
  parameter int unsigned                 DIGITS       = 4,
  parameter int unsigned                 DIGIT_W      = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   RESET_PW     = '0,
  parameter int unsigned                 MAX_TRIES    = 3,
  parameter int unsigned                 LOCK_CYCLES  = 50_000_000,
  parameter int unsigned                 BLINK_CYCLES = 25_000_000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ent,
  input  logic                             clr,
  input  logic                             change,
  input  logic [DIGIT_W-1:0]               sw,
  output logic [5*DIGITS-1:0]              ssd,
  output logic                             unlocked,
  output logic                             alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
  output logic [2:0]                       state
);
  import digilock_pkg::*;

  localparam int unsigned PW_W = DIGITS * DIGIT_W;
  localparam int unsigned IW   = $clog2(DIGITS);
  localparam int unsigned FW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TW   = $clog2(LOCK_CYCLES + 1);

  function automatic logic [5*DIGITS-1:0] tail4(input logic [19:0] t);
    logic [5*DIGITS-1:0] r;
    r       = {DIGITS{G_BLANK}};
    r[19:0] = t;
    return r;
  endfunction

  function automatic logic [PW_W-1:0] put_digit(input logic [PW_W-1:0] v,
                                                input logic [IW-1:0]   i,
                                                input logic [DIGIT_W-1:0] d);
    logic [PW_W-1:0] r;
    r = v;
    for (int unsigned k = 0; k < DIGITS; k++)
      if (i == IW'(k)) r[(DIGITS-1-k)*DIGIT_W +: DIGIT_W] = d;
    return r;
  endfunction

  localparam logic [5*DIGITS-1:0] IDLE_PAT  = tail4({G_C, G_L, G_5, G_D});
  localparam logic [5*DIGITS-1:0] OPEN_PAT  = tail4({G_0, G_P, G_E, G_N});
  localparam logic [5*DIGITS-1:0] BLANK_PAT = {DIGITS{G_BLANK}};

  state_t            st, st_n;
  logic [PW_W-1:0]   password, pw_n;
  logic [PW_W-1:0]   in_pw, in_n;
  logic [PW_W-1:0]   new_pw, new_n;
  logic [IW-1:0]     idx, idx_n;
  logic [FW-1:0]     fail_n, fail_inc;
  logic [TW-1:0]     timer, timer_n;
  logic [5*DIGITS-1:0] ssd_n;
  logic              unlocked_n, alarm_n;
  logic              last, capturing, blink_restart, blink_on;

  assign state    = st;
  assign last     = (idx == IW'(DIGITS - 1));
  assign fail_inc = fail_cnt + FW'(1);
`ifdef DIGILOCK_CONFIRM_EN
  assign capturing = (st == ENTRY) || (st == NEWPW) || (st == CONFIRM);
`else
  assign capturing = (st == ENTRY) || (st == NEWPW);
`endif

  // Restart the blink whenever the cursor moves or a blinking state is entered
  always_comb begin
    blink_restart = (idx_n != idx);
    if (st_n != st) begin
      if (st_n == ENTRY || st_n == NEWPW || st_n == LOCKOUT) blink_restart = 1'b1;
`ifdef DIGILOCK_CONFIRM_EN
      if (st_n == CONFIRM) blink_restart = 1'b1;
`endif
    end
  end

  digilock_blink #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (blink_restart),
    .phase   (blink_on)
  );

  // Next-state and datapath updates; clr is tested before ent, ent before change
  always_comb begin
    st_n    = st;
    pw_n    = password;
    in_n    = in_pw;
    new_n   = new_pw;
    idx_n   = idx;
    fail_n  = fail_cnt;
    timer_n = timer;
    case (st)
      IDLE: begin
        if (!clr && ent) begin
          st_n  = ENTRY;
          idx_n = '0;
          in_n  = '0;
        end
      end
      ENTRY: begin
        if (clr) begin
          in_n  = '0;
          idx_n = '0;
        end else if (ent) begin
          in_n = put_digit(in_pw, idx, sw);
          if (last) st_n = CHECK;
          else      idx_n = idx + IW'(1);
        end
      end
      CHECK: begin
        if (in_pw == password) begin
          st_n   = OPEN;
          fail_n = '0;
        end else begin
          fail_n = fail_inc;
          if (fail_inc == FW'(MAX_TRIES)) begin
            st_n    = LOCKOUT;
            timer_n = TW'(LOCK_CYCLES - 1);
          end else begin
            st_n = IDLE;
          end
        end
      end
      OPEN: begin
        if (clr || ent) begin
          st_n = IDLE;
        end else if (change) begin
          st_n  = NEWPW;
          idx_n = '0;
          new_n = '0;
        end
      end
      NEWPW: begin
        if (clr) begin
          st_n = OPEN;
        end else if (ent) begin
          new_n = put_digit(new_pw, idx, sw);
          if (last) begin
`ifdef DIGILOCK_CONFIRM_EN
            st_n  = CONFIRM;
            idx_n = '0;
            in_n  = '0;
`else
            pw_n = new_n;
            st_n = OPEN;
`endif
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
`ifdef DIGILOCK_CONFIRM_EN
      // in_pw doubles as the confirmation buffer; it is free outside ENTRY/CHECK
      CONFIRM: begin
        if (clr) begin
          st_n = OPEN;
        end else if (ent) begin
          in_n = put_digit(in_pw, idx, sw);
          if (last) begin
            if (in_n == new_pw) pw_n = new_pw;
            st_n = OPEN;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
`endif
      LOCKOUT: begin
        if (timer == '0) begin
          st_n   = IDLE;
          fail_n = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Glyph bus and LEDs follow the current state; CHECK holds the previous glyphs
  always_comb begin
    ssd_n      = ssd;
    unlocked_n = (st == OPEN) || (st == NEWPW);
`ifdef DIGILOCK_CONFIRM_EN
    unlocked_n = unlocked_n || (st == CONFIRM);
`endif
    alarm_n    = (st == LOCKOUT);
    if (st == IDLE) begin
      ssd_n = IDLE_PAT;
    end else if (st == OPEN) begin
      ssd_n = OPEN_PAT;
    end else if (st == LOCKOUT) begin
      ssd_n = blink_on ? IDLE_PAT : BLANK_PAT;
    end else if (capturing) begin
      for (int unsigned p = 0; p < DIGITS; p++)
        ssd_n[(DIGITS-1-p)*5 +: 5] = (IW'(p) < idx)  ? G_DASH :
                                     (IW'(p) == idx) ? (blink_on ? 5'(sw) : G_BLANK) :
                                                       G_BLANK;
    end
  end

  // State, password, entry buffers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      password <= RESET_PW;
      in_pw    <= '0;
      new_pw   <= '0;
      idx      <= '0;
      fail_cnt <= '0;
      timer    <= '0;
      ssd      <= IDLE_PAT;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      st       <= st_n;
      password <= pw_n;
      in_pw    <= in_n;
      new_pw   <= new_n;
      idx      <= idx_n;
      fail_cnt <= fail_n;
      timer    <= timer_n;
      ssd      <= ssd_n;
      unlocked <= unlocked_n;
      alarm    <= alarm_n;
    end
  end

endmodule
